// File: rtl/alu_ctrl_if.sv
// Bus bundle between alu_ctrl and its surroundings.
// It carries the start/busy/done handshake, the program-memory port, the ALU
// operand/result port, the latched flags and the register-file debug port.
// The controller uses the master view and the environment uses the slave view.
interface alu_ctrl_if #(
    parameter int W        = 8,
    parameter int MEM_SIZE = 8
);
    logic                start;
    logic                busy;
    logic                done;
    logic [MEM_SIZE-1:0] imem_addr;
    logic [15:0]         imem_data;
    logic [3:0]          alu_opcode;
    logic [W-1:0]        alu_a;
    logic [W-1:0]        alu_b;
    logic [W-1:0]        alu_result;
    logic [2:0]          alu_flag;
    logic [2:0]          flags;
    logic [1:0]          dbg_sel;
    logic [W-1:0]        dbg_data;

    modport master (
        input  start, imem_data, alu_result, alu_flag, dbg_sel,
        output busy, done, imem_addr, alu_opcode, alu_a, alu_b, flags, dbg_data
    );

    modport slave (
        output start, imem_data, alu_result, alu_flag, dbg_sel,
        input  busy, done, imem_addr, alu_opcode, alu_a, alu_b, flags, dbg_data
    );
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencing controller for a W-bit ALU.
// The controller fetches 16-bit instructions of the form {op, rd, rs, imm[7:0]}
// and presents registered operands to the external ALU.
// It writes results back to a 4-entry register file, latches the ALU flags
// ({C,Z,N}) and resolves JMP/JZ/JC.
// Each instruction takes 3 cycles: FETCH, DECODE and EXEC.
// A JMP to its own address halts the program and pulses done.
// Optional build macro ALU_CTRL_STEP_EN adds a `step` input.
// With that macro, the controller parks in a STALL state after each
// non-halting EXEC until step is high.
module alu_ctrl #(
    parameter int W        = 8,
    parameter int MEM_SIZE = 8
) (
    input  logic clk,
    input  logic rst,
`ifdef ALU_CTRL_STEP_EN
    input  logic step,
`endif
    alu_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3
`ifdef ALU_CTRL_STEP_EN
        ,S_STALL = 3'd4
`endif
    } state_t;

    localparam logic [MEM_SIZE-1:0] PC_ONE = {{(MEM_SIZE-1){1'b0}}, 1'b1};

    // Zero-extend or truncate the 8-bit immediate to the data width.
    function automatic logic [W-1:0] imm_to_data(input logic [7:0] imm);
        logic [W+7:0] ext;
        ext = {{W{1'b0}}, imm};
        return ext[W-1:0];
    endfunction

    // Zero-extend or truncate the 8-bit immediate to the program-counter width.
    function automatic logic [MEM_SIZE-1:0] imm_to_pc(input logic [7:0] imm);
        logic [MEM_SIZE+7:0] ext;
        ext = {{MEM_SIZE{1'b0}}, imm};
        return ext[MEM_SIZE-1:0];
    endfunction

    // Register-register forms take operand B from reg[rs]. Immediate forms take it from imm.
    function automatic logic is_reg_form(input logic [3:0] op);
        logic r;
        case (op)
            4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1010: r = 1'b1;
            default:                                              r = 1'b0;
        endcase
        return r;
    endfunction

    // LDI and every ALU operation except CMP write rd.
    function automatic logic writes_back(input logic [3:0] op);
        logic r;
        case (op)
            4'b0000:                   r = 1'b1;
            4'b0001, 4'b0010, 4'b0011: r = 1'b0;
            4'b0111, 4'b1111:          r = 1'b0;
            default:                   r = 1'b1;
        endcase
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [MEM_SIZE-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [3:0]          opcode_q, opcode_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [2:0]          flags_q, flags_d;
    logic [W-1:0]        regs_q [4];
    logic [W-1:0]        regs_d [4];

    logic                done_s;
    logic [3:0]          dec_op_s;
    logic [1:0]          dec_rd_s;
    logic [1:0]          dec_rs_s;
    logic [3:0]          ex_op_s;
    logic [1:0]          ex_rd_s;
    logic [MEM_SIZE-1:0] ex_target_s;
    logic                ex_taken_s;
    logic                ex_halt_s;

    // Field extraction for the word arriving from memory (DECODE) and the held instruction (EXEC).
    always_comb begin
        dec_op_s    = bus.imem_data[15:12];
        dec_rd_s    = bus.imem_data[11:10];
        dec_rs_s    = bus.imem_data[9:8];
        ex_op_s     = ir_q[15:12];
        ex_rd_s     = ir_q[11:10];
        ex_target_s = imm_to_pc(ir_q[7:0]);
        case (ex_op_s)
            4'b0001: ex_taken_s = 1'b1;
            4'b0010: ex_taken_s = flags_q[1];
            4'b0011: ex_taken_s = flags_q[2];
            default: ex_taken_s = 1'b0;
        endcase
        ex_halt_s = (ex_op_s == 4'b0001) && (ex_target_s == pc_q);
    end

    // Next-state, datapath and register-file update logic for the controller FSM.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        opcode_d = opcode_q;
        a_d      = a_q;
        b_d      = b_q;
        flags_d  = flags_q;
        regs_d   = regs_q;
        done_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pc_d    = {MEM_SIZE{1'b0}};
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d     = bus.imem_data;
                opcode_d = dec_op_s;
                if (dec_op_s[3:2] == 2'b00) begin
                    a_d = imm_to_data(bus.imem_data[7:0]);
                    b_d = {W{1'b0}};
                end else if (is_reg_form(dec_op_s)) begin
                    a_d = regs_q[dec_rd_s];
                    b_d = regs_q[dec_rs_s];
                end else begin
                    a_d = regs_q[dec_rd_s];
                    b_d = imm_to_data(bus.imem_data[7:0]);
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (writes_back(ex_op_s)) begin
                    regs_d[ex_rd_s] = bus.alu_result;
                end else begin
                    regs_d = regs_q;
                end
                if (ex_op_s[3:2] != 2'b00) begin
                    flags_d = bus.alu_flag;
                end else begin
                    flags_d = flags_q;
                end
                if (ex_taken_s) begin
                    pc_d = ex_target_s;
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
                if (ex_halt_s) begin
                    done_s  = 1'b1;
                    state_d = S_IDLE;
                end else begin
`ifdef ALU_CTRL_STEP_EN
                    state_d = step ? S_FETCH : S_STALL;
`else
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef ALU_CTRL_STEP_EN
            S_STALL: begin
                if (step) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_STALL;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and register-file flops. A reset discards any in-flight write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= {MEM_SIZE{1'b0}};
            ir_q     <= 16'h0000;
            opcode_q <= 4'b0000;
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            flags_q  <= 3'b000;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= {W{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            flags_q  <= flags_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // The memory address is the PC. During FETCH it names the word to read.
    assign bus.imem_addr  = pc_q;
    assign bus.alu_opcode = opcode_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.flags      = flags_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_s;
    assign bus.dbg_data   = regs_q[bus.dbg_sel];

endmodule
